// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for apb_master_bridge.
// The timeout feature is enabled by defining APB_MASTER_BRIDGE_TIMEOUT_EN.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Bits needed to hold the value n (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned TO_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus bundle for apb_master_bridge.
// master = bridge side, slave = requester + APB peripheral side.
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_master_bridge_timeout.sv
// ACCESS wait-state counter for apb_master_bridge; used only when
// APB_MASTER_BRIDGE_TIMEOUT_EN is defined.
module apb_timeout_counter
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam int unsigned W    = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a stalled increment can never wrap back to zero.
  always_ff @(posedge PCLK) begin
    if (PRESET || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign terminal = (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge.
// Define APB_MASTER_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_bridge_if.master  bus
);

  state_t            state;
  logic              psel_q;
  logic              penable_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              timeout_hit;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  logic rsp_error_q;
  logic terminal;

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .clr      (state != ACCESS),
    .inc      ((state == ACCESS) && !bus.PREADY),
    .terminal (terminal)
  );

  assign timeout_hit   = terminal && !bus.PREADY;
  assign bus.rsp_error = rsp_error_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.rsp_error  = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
      rsp_error_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over a timeout landing in the same cycle.
          if (bus.PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            rsp_error_q <= 1'b0;
`endif
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            rsp_error_q <= 1'b1;
`endif
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT=4).
// Covers both builds of APB_MASTER_BRIDGE_TIMEOUT_EN.
module tb_apb_master_bridge;

  logic PCLK = 1'b0;
  logic PRESET;
  int   vectors = 0;
  int   miscompares = 0;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (4)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.master)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  task automatic test_reset;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR} !== {4'b1000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b/%h expected 1000/00",
               {bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid}, bus.PADDR);
    end
    vectors++;
    if ({bus.rsp_rdata, bus.rsp_error, bus.PWRITE, bus.PWDATA} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h err=%b pwrite=%b pwdata=%h expected all 0",
               bus.rsp_rdata, bus.rsp_error, bus.PWRITE, bus.PWDATA);
    end
    tick();
    vectors++;
    if ({bus.cmd_ready, bus.PSEL, bus.rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_hold: got %b expected 100", {bus.cmd_ready, bus.PSEL, bus.rsp_valid});
    end
  endtask

  task automatic test_write_zero_wait;
    bus.PREADY    = 1'b1;
    bus.rsp_ready = 1'b0;
    issue(1'b1, 8'h10, 8'hA5);
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.cmd_ready} !==
        {1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b expected 1 0 1 10 a5 0",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.cmd_ready);
    end
    tick();
    vectors++;
    if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {2'b11, 8'h10, 8'hA5}) begin
      miscompares++;
      $display("FAIL wr_access: got sel=%b en=%b addr=%h wdata=%h expected 1 1 10 a5",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA);
    end
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.PSEL, bus.PENABLE} !== {1'b1, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL wr_resp: got valid=%b rdata=%h err=%b sel=%b en=%b expected 1 00 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.PSEL, bus.PENABLE);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.PADDR, bus.PWRITE, bus.PWDATA} !== {2'b10, 8'h10, 1'b1, 8'hA5}) begin
      miscompares++;
      $display("FAIL wr_done: got rdy=%b valid=%b addr=%h wr=%b wdata=%h expected 1 0 10 1 a5",
               bus.cmd_ready, bus.rsp_valid, bus.PADDR, bus.PWRITE, bus.PWDATA);
    end
  endtask

  task automatic test_read_wait_states;
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'hEE;
    issue(1'b0, 8'h20, 8'h77);
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 8'h20}) begin
      miscompares++;
      $display("FAIL rd_setup: got sel=%b en=%b wr=%b addr=%h expected 1 0 0 20",
               bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      vectors++;
      if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin
        miscompares++;
        $display("FAIL rd_wait_c%0d: got %b expected 110", c, {bus.PSEL, bus.PENABLE, bus.rsp_valid});
      end
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h5C;
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error} !== {1'b1, 8'h5C, 1'b0}) begin
      miscompares++;
      $display("FAIL rd_resp_c6: got valid=%b rdata=%h err=%b expected 1 5c 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_done: got cmd_ready=%b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_backpressure;
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'hC3;
    issue(1'b0, 8'h30, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    bus.PRDATA = 8'h00;
    issue(1'b1, 8'h99, 8'h11);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.cmd_ready, bus.PSEL} !== {1'b1, 8'hC3, 3'b000}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b rdy=%b sel=%b expected 1 c3 0 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.cmd_ready, bus.PSEL);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.PADDR} !== {2'b10, 8'h30}) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b valid=%b addr=%h expected 1 0 30",
               bus.cmd_ready, bus.rsp_valid, bus.PADDR);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int t0 = 0, t1 = 0;
    logic [7:0] r0 = 8'hFF, r1 = 8'hFF;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 8'h99;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 8'h55, 8'h3C);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h66;
      end
      if (bus.rsp_valid === 1'b1) begin
        if (n == 0) begin
          t0 = c;
          r0 = bus.rsp_rdata;
        end else if (n == 1) begin
          t1 = c;
          r1 = bus.rsp_rdata;
          bus.cmd_valid = 1'b0;
        end
        n++;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    vectors++;
    if (n != 2 || t0 != 3 || t1 != 7) begin
      miscompares++;
      $display("FAIL b2b_timing: got n=%0d t0=%0d t1=%0d expected n=2 t0=3 t1=7", n, t0, t1);
    end
    vectors++;
    if ({r0, r1, bus.PADDR} !== {8'h00, 8'h99, 8'h66}) begin
      miscompares++;
      $display("FAIL b2b_data: got r0=%h r1=%h addr=%h expected 00 99 66", r0, r1, bus.PADDR);
    end
  endtask

  task automatic test_timeout;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'hAB;
    issue(1'b0, 8'h44, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      vectors++;
      if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin
        miscompares++;
        $display("FAIL to_wait_c%0d: got %b expected 110", c, {bus.PSEL, bus.PENABLE, bus.rsp_valid});
      end
    end
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata, bus.PSEL, bus.PENABLE} !== {2'b11, 8'h00, 2'b00}) begin
      miscompares++;
      $display("FAIL to_abort: got valid=%b err=%b rdata=%h sel=%b en=%b expected 1 1 00 0 0",
               bus.rsp_valid, bus.rsp_error, bus.rsp_rdata, bus.PSEL, bus.PENABLE);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'h45, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h6E;
    tick();
    vectors++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 8'h6E}) begin
      miscompares++;
      $display("FAIL to_pready_wins: got valid=%b err=%b rdata=%h expected 1 0 6e",
               bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
`else
    bus.PREADY = 1'b0;
    issue(1'b0, 8'h44, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (100) tick();
    vectors++;
    if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, bus.rsp_error} !== 5'b11000) begin
      miscompares++;
      $display("FAIL no_timeout: got sel/en/valid/rdy/err=%b expected 11000",
               {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, bus.rsp_error});
    end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_access;
    int seen = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'h42;
    issue(1'b0, 8'h5A, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_pre: got sel=%b en=%b expected 1 1", bus.PSEL, bus.PENABLE);
    end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    vectors++;
    if ({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR, bus.PWRITE, bus.PWDATA,
         bus.rsp_rdata, bus.rsp_error} !== {4'b1000, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b sel=%b en=%b valid=%b addr=%h wr=%b wdata=%h rdata=%h err=%b expected 1 0 0 0 00 0 00 00 0",
               bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR, bus.PWRITE,
               bus.PWDATA, bus.rsp_rdata, bus.rsp_error);
    end
    bus.PREADY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_no_resp: got rsp_valid cycles=%0d rdy=%b expected 0 1", seen, bus.cmd_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached expected run to complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
